// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial ALU datapath family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// State encoding is shared so a future serial adder/comparator sequences identically.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full-subtractor cell: diff_o = a_i - b_i - bin_i, borrow out on bout_o.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i, bin_i (inputs); diff_o, bout_o (outputs).
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  // Borrow when a<b outright, or when a==b and a borrow is already pending.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, one bit per cycle.
// Latency: done pulses WIDTH cycles after start is accepted; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst_n, start, a, b, bin (inputs); busy, done, diff, bout, zero, ovf (outputs).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  // Operand MSBs kept aside because the shift registers are consumed.
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic cell_diff;
  logic cell_bout;

  full_subtractor u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (brw_q),
    .diff_o (cell_diff),
    .bout_o (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = cell_bout;
        // Result fills from the MSB side, so after WIDTH shifts bit 0 lands at index 0.
        res_d = {cell_diff, res_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          // Visible outputs take the completed result in one step; no partial values leak.
          diff_d  = res_d;
          bout_d  = cell_bout;
          zero_d  = (res_d == '0);
          ovf_d   = (amsb_q != bmsb_q) && (cell_diff != amsb_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       zero;
  logic       ovf;

  int n_chk;
  int n_pass;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one operation from IDLE and watches 20 cycles after acceptance.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic [7:0] ed, input logic eb,
                       input logic ez, input logic eo);
    int lat;
    int pulses;
    int busy_cyc;
    int chg;
    logic [7:0] d0;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; pulses = 0; busy_cyc = 0; chg = 0;
    d0 = diff;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        pulses++;
        if (lat < 0) lat = i;
      end
      if (i < 8 && diff !== d0) chg++;
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, lat, 8);
    chk({tag, " done_pulses"}, pulses, 1);
    chk({tag, " busy_cycles"}, busy_cyc, 9);
    chk({tag, " diff_stable"}, chg, 0);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " bout"}, bout, eb);
    chk({tag, " zero"}, zero, ez);
    chk({tag, " ovf"}, ovf, eo);
    chk({tag, " idle_busy"}, busy, 0);
  endtask

  initial begin
    int pulses;
    int busy_cyc;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset state
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst diff", diff, 0);
    chk("rst bout", bout, 0);
    chk("rst zero", zero, 0);
    chk("rst ovf", ovf, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("op1 50-20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    do_op("op2 20-50", 8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0);
    do_op("op3 80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    do_op("op3 7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
    do_op("op4 05-04-1", 8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // start during SHIFT must be ignored
    a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; busy_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        a = 8'hFF; b = 8'h00; start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) pulses++;
      @(posedge clk); #1;
    end
    chk("ign done_pulses", pulses, 1);
    chk("ign busy_cycles", busy_cyc, 9);
    chk("ign diff", diff, 8'h30);
    chk("ign bout", bout, 0);

    // Leave nonzero flags visible so the reset clear is observable
    do_op("pre 7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);

    // Async reset mid-operation
    a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    chk("mid busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst diff", diff, 0);
    chk("arst bout", bout, 0);
    chk("arst zero", zero, 0);
    chk("arst ovf", ovf, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      if (busy) busy_cyc++;
      @(posedge clk); #1;
    end
    chk("arst no_done", pulses, 0);
    chk("arst idle_after", busy, 0);

    do_op("post 10-01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
